// File: rtl/fp_add_pkg.sv
// Shared widths, constants and FSM encoding for the floating-point adder
// normalization stage.
package fp_add_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_MANT_W = 25;
    localparam int EXP_INT_W = 10;

    localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } norm_state_t;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero count of a 24-bit mantissa (24 when all zero).
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit is the last one to update count.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_normalizer.sv
// Normalizes the raw adder sum with a multi-cycle FSM, rounds to nearest-even
// and returns an IEEE-754 single-precision word over valid/ready.
module fp_add_normalizer
    import fp_add_pkg::*;
#(
    parameter int SHIFT_STEP = 1,
    parameter bit ROUND_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [FP_EXP_W-1:0]  in_exp,
    input  logic [FP_MANT_W-1:0] in_mant,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 flag_zero,
    output logic                 flag_ovf,
    output logic                 flag_sub
);

    norm_state_t state_reg, state_next;

    logic                 sign_reg, sign_next;
    logic [EXP_INT_W-1:0] exp_reg, exp_next;
    logic [FP_MANT_W-1:0] mant_reg, mant_next;
    logic                 guard_reg, guard_next;
    logic                 sticky_reg, sticky_next;
    logic                 zero_reg, zero_next;
    logic [31:0]          result_reg, result_next;
    logic                 flag_zero_reg, flag_zero_next;
    logic                 flag_ovf_reg, flag_ovf_next;
    logic                 flag_sub_reg, flag_sub_next;

    logic [4:0]           lzc_count;
    logic [EXP_INT_W-1:0] shift_n;
    logic                 round_up;
    logic [FP_MANT_W-1:0] mant_rnd;
    logic [EXP_INT_W-1:0] exp_rnd;

    generate
        if (SHIFT_STEP > 1) begin : g_lzc
            fp_lzc24 u_lzc (
                .value (mant_reg[23:0]),
                .count (lzc_count)
            );
        end else begin : g_no_lzc
            // A single-bit step never needs the true count: lzc >= 1 whenever we shift.
            assign lzc_count = 5'd1;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        sign_next      = sign_reg;
        exp_next       = exp_reg;
        mant_next      = mant_reg;
        guard_next     = guard_reg;
        sticky_next    = sticky_reg;
        zero_next      = zero_reg;
        result_next    = result_reg;
        flag_zero_next = flag_zero_reg;
        flag_ovf_next  = flag_ovf_reg;
        flag_sub_next  = flag_sub_reg;

        // Left-shift distance: bounded by step size, leading zeros and exponent floor of 1.
        shift_n = EXP_INT_W'(SHIFT_STEP);
        if ({5'd0, lzc_count} < shift_n) begin
            shift_n = {5'd0, lzc_count};
        end
        if ((exp_reg - 10'd1) < shift_n) begin
            shift_n = exp_reg - 10'd1;
        end

        round_up = ROUND_EN && guard_reg && (sticky_reg || mant_reg[0]);
        mant_rnd = mant_reg + {{(FP_MANT_W-1){1'b0}}, round_up};
        exp_rnd  = exp_reg;
        if (mant_rnd[FP_MANT_W-1]) begin
            mant_rnd = mant_rnd >> 1;
            exp_rnd  = exp_reg + 10'd1;
        end

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_next   = in_sign;
                    exp_next    = {2'b00, in_exp};
                    mant_next   = in_mant;
                    sticky_next = in_sticky;
                    guard_next  = 1'b0;
                    zero_next   = 1'b0;
                    state_next  = NORM;
                end
            end
            NORM: begin
                if (mant_reg == '0) begin
                    zero_next  = 1'b1;
                    state_next = ROUND;
                end else if (mant_reg[24]) begin
                    guard_next  = mant_reg[0];
                    sticky_next = sticky_reg | guard_reg;
                    mant_next   = mant_reg >> 1;
                    exp_next    = exp_reg + 10'd1;
                end else if (mant_reg[23] || (exp_reg <= 10'd1)) begin
                    state_next = ROUND;
                end else begin
                    mant_next  = (mant_reg << shift_n)
                               | ({{(FP_MANT_W-1){1'b0}}, guard_reg} << (shift_n - 10'd1));
                    guard_next = 1'b0;
                    exp_next   = exp_reg - shift_n;
                end
            end
            ROUND: begin
                flag_zero_next = 1'b0;
                flag_ovf_next  = 1'b0;
                flag_sub_next  = 1'b0;
                if (exp_rnd >= 10'd255) begin
                    result_next   = {sign_reg, EXP_MAX, {FP_FRAC_W{1'b0}}};
                    flag_ovf_next = 1'b1;
                end else if (zero_reg) begin
                    result_next    = {sign_reg, 31'd0};
                    flag_zero_next = 1'b1;
                end else if ((exp_rnd == 10'd1) && !mant_rnd[23]) begin
                    result_next   = {sign_reg, 8'h00, mant_rnd[FP_FRAC_W-1:0]};
                    flag_sub_next = 1'b1;
                end else begin
                    result_next = {sign_reg, exp_rnd[FP_EXP_W-1:0], mant_rnd[FP_FRAC_W-1:0]};
                end
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mant_reg      <= '0;
            guard_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            zero_reg      <= 1'b0;
            result_reg    <= '0;
            flag_zero_reg <= 1'b0;
            flag_ovf_reg  <= 1'b0;
            flag_sub_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sign_reg      <= sign_next;
            exp_reg       <= exp_next;
            mant_reg      <= mant_next;
            guard_reg     <= guard_next;
            sticky_reg    <= sticky_next;
            zero_reg      <= zero_next;
            result_reg    <= result_next;
            flag_zero_reg <= flag_zero_next;
            flag_ovf_reg  <= flag_ovf_next;
            flag_sub_reg  <= flag_sub_next;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == HOLD);
    assign out_result = result_reg;
    assign flag_zero  = flag_zero_reg;
    assign flag_ovf   = flag_ovf_reg;
    assign flag_sub   = flag_sub_reg;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Bench for fp_add_normalizer: three instances (step 1 rounding, step 1 truncating,
// step 4 rounding) share stimulus and are compared against a closed-form model.
module tb_fp_add_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy [3];
    logic        ov  [3];
    logic [31:0] res [3];
    logic        fz  [3];
    logic        fo  [3];
    logic        fs  [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cap_res [3];
    logic        cap_fz  [3];
    logic        cap_fo  [3];
    logic        cap_fs  [3];
    int          cap_lat;
    bit          cap_timeout;

    always #5 clk = ~clk;

    fp_add_normalizer #(.SHIFT_STEP(1), .ROUND_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(ov[0]), .out_ready(out_ready), .out_result(res[0]),
        .flag_zero(fz[0]), .flag_ovf(fo[0]), .flag_sub(fs[0]));

    fp_add_normalizer #(.SHIFT_STEP(1), .ROUND_EN(1'b0)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(ov[1]), .out_ready(out_ready), .out_result(res[1]),
        .flag_zero(fz[1]), .flag_ovf(fo[1]), .flag_sub(fs[1]));

    fp_add_normalizer #(.SHIFT_STEP(4), .ROUND_EN(1'b1)) u_dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(ov[2]), .out_ready(out_ready), .out_result(res[2]),
        .flag_zero(fz[2]), .flag_ovf(fo[2]), .flag_sub(fs[2]));

    // Value-level reference: total shift computed in closed form, then round and classify.
    function automatic void model(input bit s, input int ex, input int m, input bit st,
                                  input bit rnd, output logic [31:0] r, output bit mz,
                                  output bit mo, output bit ms, output int k);
        int mi, e, g, sh, lim, p;
        bit z;
        mi = m; e = ex; g = 0; k = 0; z = 0;
        mz = 0; mo = 0; ms = 0;
        if (mi == 0) begin
            z = 1;
        end else if (mi >= 32'h100_0000) begin
            g = mi & 1; mi = mi >> 1; e = e + 1; k = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (((mi >> i) & 1) == 1) p = i;
            sh  = 23 - p;
            lim = (e > 1) ? e - 1 : 0;
            if (sh > lim) sh = lim;
            mi = mi << sh; e = e - sh; k = sh;
        end
        if (rnd && g == 1 && (st || (mi & 1) == 1)) mi = mi + 1;
        if (mi >= 32'h100_0000) begin mi = mi >> 1; e = e + 1; end
        if (e >= 255) begin
            r = {s, 8'hFF, 23'h0}; mo = 1;
        end else if (z) begin
            r = {s, 31'h0}; mz = 1;
        end else if (e == 1 && ((mi >> 23) & 1) == 0) begin
            r = {s, 8'h00, 23'(mi)}; ms = 1;
        end else begin
            r = {s, 8'(e), 23'(mi)};
        end
    endfunction

    // Drives one accepted transaction and waits (bounded) until all instances hold a result.
    task automatic run_op(input bit s, input logic [7:0] e, input logic [24:0] m, input bit st);
        int n;
        in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; cap_lat = -1;
        while (n < 300 && !(ov[0] && ov[1] && ov[2])) begin
            @(posedge clk); #1;
            n++;
            if (ov[0] && cap_lat < 0) cap_lat = n;
        end
        cap_timeout = !(ov[0] && ov[1] && ov[2]);
        for (int i = 0; i < 3; i++) begin
            cap_res[i] = res[i]; cap_fz[i] = fz[i]; cap_fo[i] = fo[i]; cap_fs[i] = fs[i];
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1 || ov[i] !== 1'b0 || res[i] !== 32'h0 ||
                {fz[i], fo[i], fs[i]} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset dut%0d: in_ready=%b out_valid=%b result=%h flags=%b%b%b required 1 0 00000000 000",
                         i, rdy[i], ov[i], res[i], fz[i], fo[i], fs[i]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        // {sign, exp, mant, sticky, result, zero/ovf/sub, latency, truncated result}
        logic [7:0]  t_e   [6] = '{8'd127, 8'd130, 8'd3, 8'd100, 8'd254, 8'd127};
        logic [24:0] t_m   [6] = '{25'h100_0000, 25'h1, 25'h100, 25'h0, 25'h100_0000, 25'h1FF_FFFF};
        logic        t_s   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_r   [6] = '{32'h4000_0000, 32'h3580_0000, 32'h0000_0400,
                                   32'h8000_0000, 32'h7F80_0000, 32'h4080_0000};
        logic [31:0] t_rt  [6] = '{32'h4000_0000, 32'h3580_0000, 32'h0000_0400,
                                   32'h8000_0000, 32'h7F80_0000, 32'h407F_FFFF};
        logic [2:0]  t_f   [6] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b010, 3'b000};
        int          t_lat [6] = '{3, 25, 4, 2, 3, 3};
        for (int c = 0; c < 6; c++) begin
            run_op(t_s[c], t_e[c], t_m[c], 1'b0);
            n_checks++;
            if (cap_timeout) begin
                n_fail++; $display("FAIL directed%0d timeout: out_valid never seen", c);
            end
            n_checks++;
            if (cap_res[0] !== t_r[c] || {cap_fz[0], cap_fo[0], cap_fs[0]} !== t_f[c]) begin
                n_fail++;
                $display("FAIL directed%0d result: got %h flags %b%b%b, required %h flags %b",
                         c, cap_res[0], cap_fz[0], cap_fo[0], cap_fs[0], t_r[c], t_f[c]);
            end
            n_checks++;
            if (cap_lat !== t_lat[c]) begin
                n_fail++; $display("FAIL directed%0d latency: got %0d required %0d", c, cap_lat, t_lat[c]);
            end
            n_checks++;
            if (cap_res[1] !== t_rt[c]) begin
                n_fail++; $display("FAIL directed%0d truncate: got %h required %h", c, cap_res[1], t_rt[c]);
            end
            n_checks++;
            if (cap_res[2] !== t_r[c] || {cap_fz[2], cap_fo[2], cap_fs[2]} !== t_f[c]) begin
                n_fail++; $display("FAIL directed%0d step4: got %h required %h", c, cap_res[2], t_r[c]);
            end
            release_out();
            n_checks++;
            if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                n_fail++; $display("FAIL directed%0d release: out_valid=%b in_ready=%b required 0 1", c, ov[0], rdy[0]);
            end
            $display("directed %0d: result %h latency %0d", c, cap_res[0], cap_lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] r_rnd, r_tr;
        bit mz, mo, ms, tz, to, ts;
        int k, kt, kind;
        bit s, st;
        logic [7:0] e;
        logic [24:0] m;
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 7));
            s  = 1'($urandom);
            st = 1'($urandom);
            e  = (kind >= 5) ? 8'($urandom_range(1, 8)) : 8'($urandom_range(1, 254));
            case (kind)
                0, 5:    m = 25'($urandom);
                1, 6:    m = 25'(($urandom & 32'hFF_FFFF) >> $urandom_range(0, 23));
                2:       m = 25'h100_0000 | 25'($urandom);
                3:       m = 25'h100_0000 | 25'($urandom & 32'h3);
                4:       m = 25'h0;
                default: m = 25'h0FF_FFFF;
            endcase
            model(s, int'(e), int'(m), st, 1'b1, r_rnd, mz, mo, ms, k);
            model(s, int'(e), int'(m), st, 1'b0, r_tr, tz, to, ts, kt);
            run_op(s, e, m, st);
            n_checks++;
            if (cap_timeout) begin
                n_fail++; $display("FAIL random%0d timeout: out_valid never seen", t);
            end
            n_checks++;
            if (cap_res[0] !== r_rnd || {cap_fz[0], cap_fo[0], cap_fs[0]} !== {mz, mo, ms}) begin
                n_fail++;
                $display("FAIL random%0d rne: in %b %h %h %b got %h flags %b%b%b required %h flags %b%b%b",
                         t, s, e, m, st, cap_res[0], cap_fz[0], cap_fo[0], cap_fs[0], r_rnd, mz, mo, ms);
            end
            n_checks++;
            if (cap_lat !== 2 + k) begin
                n_fail++; $display("FAIL random%0d latency: got %0d required %0d", t, cap_lat, 2 + k);
            end
            n_checks++;
            if (cap_res[1] !== r_tr || {cap_fz[1], cap_fo[1], cap_fs[1]} !== {tz, to, ts}) begin
                n_fail++; $display("FAIL random%0d truncate: got %h required %h", t, cap_res[1], r_tr);
            end
            n_checks++;
            if (cap_res[2] !== r_rnd || {cap_fz[2], cap_fo[2], cap_fs[2]} !== {mz, mo, ms}) begin
                n_fail++; $display("FAIL random%0d step4: got %h required %h", t, cap_res[2], r_rnd);
            end
            $display("random %0d: in %b %h %h %b -> %h latency %0d", t, s, e, m, st, cap_res[0], cap_lat);
            release_out();
        end
    endtask

    task automatic test_backpressure();
        run_op(1'b1, 8'd140, 25'h000_0F3, 1'b1);
        // Offer a new operand during HOLD; it must be ignored.
        in_sign = 1'b0; in_exp = 8'd10; in_mant = 25'h100_0000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ov[0] !== 1'b1 || rdy[0] !== 1'b0 || res[0] !== cap_res[0] ||
                {fz[0], fo[0], fs[0]} !== {cap_fz[0], cap_fo[0], cap_fs[0]}) begin
                n_fail++;
                $display("FAIL hold cycle%0d: out_valid=%b in_ready=%b result=%h required 1 0 %h",
                         c, ov[0], rdy[0], res[0], cap_res[0]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL hold no-accept: in_ready=%b out_valid=%b required 1 0", rdy[0], ov[0]);
        end
        $display("backpressure: held result %h for 5 cycles", cap_res[0]);
    endtask

    task automatic test_reset_mid();
        bit seen;
        in_sign = 1'b0; in_exp = 8'd130; in_mant = 25'h1; in_sticky = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1 || ov[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid dut%0d: in_ready=%b out_valid=%b required 1 0", i, rdy[i], ov[i]);
            end
        end
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ov[0] || ov[1] || ov[2]) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL reset_mid output: out_valid=1 required 0 after abort");
        end
        $display("reset mid-operation: aborted, out_valid seen=%b", seen);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
